// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory between the core datapath and a debug/loader
// master. The core owns the memory by default. A pending debug request is
// granted when the core is idle, when dbg_halt is set, or after it has
// waited STARVE_LIMIT core-busy cycles. Each debug access is one S_DBG
// cycle followed by one S_ACK cycle.
//
// Handshake: the debug master raises dbg_req with dbg_we/dbg_addr/dbg_wdata
// stable and holds them until it sees dbg_ack (a one-cycle pulse, with
// dbg_rdata valid in that cycle for reads). In the cycle after dbg_ack it
// either drops dbg_req or presents the next request.
//
// Ports:
//   clk, rst_n          clock; synchronous reset, active-high despite name
//   core_mem_*          core memory request (read/write strobes, addr, data)
//   core_rdata          read data to core (pass-through of mem_rdata)
//   core_stall          core must hold its PC and memory request
//   dbg_req/we/addr/wdata  debug request
//   dbg_halt            freeze core and grant debug immediately
//   dbg_ack, dbg_rdata  debug completion pulse and registered read data
//   mem_*               DataMem port (combinational read, write on clk)
//   fsm_state           current arbiter state, for observation
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_mem_write,
    input  logic          core_mem_read,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_halt,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        S_CORE = 2'd0,
        S_DBG  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          core_busy;

    assign core_busy = core_mem_read | core_mem_write;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_CORE;
            wait_cnt_q  <= 8'd0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_CORE: begin
                if (dbg_req && (dbg_halt || !core_busy || wait_cnt_q == LIMIT)) begin
                    state_d = S_DBG;
                end else if (dbg_req) begin
                    // Core is busy: count the wait, saturating.
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    wait_cnt_d = 8'd0;
                end
            end
            S_DBG: begin
                state_d = S_ACK;
                // Reads capture at the edge; writes leave the old value.
                if (!dbg_we) begin
                    dbg_rdata_d = mem_rdata;
                end
            end
            S_ACK: begin
                state_d    = S_CORE;
                wait_cnt_d = 8'd0;
            end
            default: begin
                state_d    = S_CORE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Output logic. Reset forces the memory strobes and stall low, so a
    // debug write caught by reset in S_DBG never reaches memory.
    always_comb begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        core_stall = 1'b0;
        dbg_ack    = 1'b0;
        if (!rst_n) begin
            case (state_q)
                S_DBG: begin
                    core_stall = 1'b1;
                    mem_addr   = dbg_addr;
                    mem_wdata  = dbg_wdata;
                    mem_write  = dbg_we;
                    mem_read   = !dbg_we;
                end
                S_ACK: begin
                    dbg_ack    = 1'b1;
                    core_stall = dbg_halt;
                    mem_write  = core_mem_write & ~dbg_halt;
                    mem_read   = core_mem_read & ~dbg_halt;
                end
                default: begin
                    // A halted core is stalled, so its strobes are masked.
                    core_stall = dbg_halt;
                    mem_write  = core_mem_write & ~dbg_halt;
                    mem_read   = core_mem_read & ~dbg_halt;
                end
            endcase
        end
    end

    assign core_rdata = mem_rdata;
    assign dbg_rdata  = dbg_rdata_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int STARVE = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        core_mem_write, core_mem_read;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        core_stall;
  logic        dbg_req, dbg_we, dbg_halt, dbg_ack;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        mem_write, mem_read;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  fsm_state;

  dmem_arbiter #(.AW(8), .DW(32), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst),
    .core_mem_write(core_mem_write), .core_mem_read(core_mem_read),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_halt(dbg_halt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // DataMem: combinational read, write on clk, plus a preload port
  logic [31:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // scoreboard / reference model state
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q[$];
  logic [31:0] exp_hold = '0;
  bit  acc_pending = 0;
  bit  ack_pending = 0;
  int  waited = 0;
  bit  last_ack = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle_begin();
    @(negedge clk);
  endtask

  // Check this cycle's outputs against the model, then advance the model.
  task automatic cycle_end();
    logic        e_acc, e_ack, e_mw, e_mr, e_stall;
    logic [7:0]  e_addr;
    logic [31:0] e_wd, popped;
    #1;
    e_acc = !rst && acc_pending;
    e_ack = !rst && ack_pending;
    e_addr = core_addr;
    e_wd = core_wdata;
    if (rst) begin
      e_mw = 0; e_mr = 0; e_stall = 0;
    end else if (e_acc) begin
      e_stall = 1; e_mw = dbg_we; e_mr = !dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
    end else begin
      e_stall = dbg_halt;
      e_mw = core_mem_write && !dbg_halt;
      e_mr = core_mem_read && !dbg_halt;
    end
    chk("mem_write", mem_write, e_mw);
    chk("mem_read", mem_read, e_mr);
    chk("core_stall", core_stall, e_stall);
    chk("dbg_ack", dbg_ack, e_ack);
    chk("dbg_rdata_hold", dbg_rdata, exp_hold);
    if (e_mw || e_mr) chk("mem_addr", mem_addr, e_addr);
    if (e_mw) chk("mem_wdata", mem_wdata, e_wd);
    if (e_mr) chk("core_rdata", core_rdata, ref_mem[e_addr]);
    if (e_ack && exp_q.size() > 0) begin
      popped = exp_q.pop_front();
      chk("dbg_rdata_ack", dbg_rdata, popped);
    end

    if (rst) begin
      acc_pending = 0; ack_pending = 0; waited = 0; exp_hold = '0;
      exp_q.delete();
    end else if (e_acc) begin
      if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      else begin
        exp_hold = ref_mem[dbg_addr];
        exp_q.push_back(exp_hold);
      end
      acc_pending = 0;
      ack_pending = 1;
    end else begin
      if (e_mw) ref_mem[core_addr] = core_wdata;
      if (e_ack) begin
        ack_pending = 0;
        waited = 0;
      end else if (dbg_req) begin
        if (dbg_halt || !(core_mem_read || core_mem_write) || waited == STARVE) acc_pending = 1;
        else if (waited < 255) waited++;
      end else begin
        waited = 0;
      end
    end
    last_ack = e_ack;
  endtask

  // Run until dbg_ack is seen (cycle 0 already has its inputs applied).
  task automatic wait_ack(output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cycle_begin();
      cycle_end();
      if (dbg_ack) begin
        at = k;
        break;
      end
    end
    if (at < 0) $display("FAIL ack_timeout: got none expected ack within 20 cycles");
  endtask

  task automatic idle_inputs();
    core_mem_write = 0; core_mem_read = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 0;
  endtask

  initial begin
    int at;
    int ack_k[2];
    int n_acks;
    logic [31:0] old_v;

    // preload memory while held in reset
    rst = 1; ld_en = 0; ld_addr = '0; ld_data = '0;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_en = 1; ld_addr = 8'(i); ld_data = $urandom;
      ref_mem[i] = ld_data;
    end
    @(negedge clk);
    ld_en = 0;

    // reset with a debug request pending and the core reading
    for (int i = 0; i < 2; i++) begin
      cycle_begin();
      rst = 1; dbg_req = 1; dbg_addr = 8'h05; core_mem_read = 1; core_addr = 8'h10;
      cycle_end();
    end
    cycle_begin();
    rst = 0; dbg_req = 0; core_mem_read = 1; core_addr = 8'h10;
    cycle_end();
    chk("post_rst_read", core_rdata, ref_mem[8'h10]);

    // idle core, debug write of 0x20
    cycle_begin();
    idle_inputs();
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h20; dbg_wdata = 32'hDEADBEEF;
    wait_ack(at);
    chk("lat_idle", 32'(at), 32'd2);
    cycle_begin();
    idle_inputs();
    core_mem_read = 1; core_addr = 8'h20;
    cycle_end();
    chk("core_sees_dbg_wr", core_rdata, 32'hDEADBEEF);

    // continuously busy core, debug read of 0x20
    cycle_begin();
    idle_inputs();
    core_mem_read = 1; core_addr = 8'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h20;
    wait_ack(at);
    chk("lat_busy", 32'(at), 32'(STARVE + 2));
    chk("busy_rdata", dbg_rdata, 32'hDEADBEEF);

    // halt with a core write pending
    old_v = ref_mem[8'h30];
    cycle_begin();
    idle_inputs();
    dbg_halt = 1; core_mem_write = 1; core_addr = 8'h30; core_wdata = 32'hCAFEF00D;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h00;
    wait_ack(at);
    chk("lat_halt", 32'(at), 32'd2);
    cycle_begin();
    dbg_req = 0;
    cycle_end();
    chk("halt_nowrite", mem[8'h30], old_v);
    cycle_begin();
    dbg_halt = 0;
    cycle_end();
    cycle_begin();
    idle_inputs();
    core_mem_read = 1; core_addr = 8'h30;
    cycle_end();
    chk("halt_release_wr", core_rdata, 32'hCAFEF00D);

    // back-to-back debug requests, idle core
    cycle_begin();
    idle_inputs();
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h11;
    n_acks = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        cycle_begin();
        if (last_ack) begin
          dbg_addr = 8'h12;
        end
      end
      cycle_end();
      if (dbg_ack && n_acks < 2) begin
        ack_k[n_acks] = k;
        n_acks++;
      end
    end
    chk("b2b_count", 32'(n_acks), 32'd2);
    if (n_acks == 2) begin
      chk("b2b_ack0", 32'(ack_k[0]), 32'd2);
      chk("b2b_ack1", 32'(ack_k[1]), 32'd5);
    end

    // reset during the access cycle of a debug write
    old_v = ref_mem[8'h40];
    cycle_begin();
    idle_inputs();
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 32'h12345678;
    cycle_end();
    cycle_begin();
    rst = 1;
    cycle_end();
    cycle_begin();
    rst = 0; dbg_req = 0; dbg_we = 0; core_mem_read = 1; core_addr = 8'h40;
    cycle_end();
    chk("rst_drop_wr", core_rdata, old_v);
    chk("rst_no_ack", dbg_ack, 1'b0);

    // randomized traffic
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      cycle_begin();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) dbg_halt = !dbg_halt;
      core_mem_read = 0; core_mem_write = 0;
      case ($urandom_range(0, 3))
        0: ;
        1: core_mem_write = 1;
        default: core_mem_read = 1;
      endcase
      core_addr = 8'($urandom_range(0, 15));
      core_wdata = $urandom;
      if (last_ack) begin
        dbg_req = 0;
        if ($urandom_range(0, 1) == 1) begin
          dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = $urandom;
        end
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = $urandom;
      end
      cycle_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
